// File: rtl/risc_v_pkg.sv
// rtl/risc_v_pkg.sv - shared types, funct3/opcode constants and decode helpers for the load/store unit
package risc_v_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_REQ2,
        S_WAIT2,
        S_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    function automatic logic [3:0] size_bytes(size_t s);
        return 4'd1 << s;
    endfunction

    function automatic logic f3_legal(logic store, logic [2:0] f3, logic is64);
        if (store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) || (is64 && f3 == F3_SD);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) ||
               (f3 == F3_LHU) || (is64 && (f3 == F3_LD || f3 == F3_LWU));
    endfunction

endpackage

// File: rtl/risc_v_lsu_if.sv
// rtl/risc_v_lsu_if.sv - decode-side request/writeback and data-memory bus bundle
interface risc_v_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_store;
    logic [2:0]           req_funct3;
    logic [XLEN-1:0]      req_base;
    logic [11:0]          req_imm;
    logic [XLEN-1:0]      req_wdata;
    logic [4:0]           req_rd;
    logic                 resp_valid;
    logic                 resp_err;
    logic                 rd_we;
    logic [4:0]           rd_addr;
    logic [XLEN-1:0]      rd_data;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [XLEN/8-1:0]    mem_be;
    logic [XLEN-1:0]      mem_wdata;
    logic                 mem_resp_valid;
    logic [XLEN-1:0]      mem_rdata;

    modport master (
        input  req_valid, req_store, req_funct3, req_base, req_imm, req_wdata, req_rd,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_err, rd_we, rd_addr, rd_data,
        output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_base, req_imm, req_wdata, req_rd,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_err, rd_we, rd_addr, rd_data,
        input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store data shift, load extract/merge and sign/zero extension
module lsu_align
    import risc_v_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int NB2 = 2 * NB,
    localparam int OFF_W = $clog2(NB)
) (
    input  size_t            i_size,
    input  logic [OFF_W-1:0] i_off,
    input  logic             i_hi,
    input  logic             i_uns,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdata_lo,
    input  logic [XLEN-1:0]  i_rdata_hi,
    output logic [NB-1:0]    o_be,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_ldata
);
    logic [3:0]        w_nbytes;
    logic [NB2-1:0]    w_be_full;
    logic [2*XLEN-1:0] w_wd_full;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_keep;
    logic              w_sign;

    // Everything is computed over a two-word window; i_hi picks the upper word for the second beat.
    always_comb begin
        w_nbytes  = size_bytes(i_size);
        w_be_full = NB2'((1 << w_nbytes) - 1) << i_off;
        w_wd_full = {XLEN'(0), i_wdata} << {i_off, 3'b000};
        o_be      = i_hi ? w_be_full[NB2-1:NB] : w_be_full[NB-1:0];
        o_wdata   = i_hi ? w_wd_full[2*XLEN-1:XLEN] : w_wd_full[XLEN-1:0];
        w_raw     = XLEN'({i_rdata_hi, i_rdata_lo} >> {i_off, 3'b000});
        w_keep    = (int'(w_nbytes) >= NB) ? '1 : ((XLEN'(1) << {w_nbytes, 3'b000}) - XLEN'(1));
        w_sign    = |(w_raw & (w_keep ^ (w_keep >> 1)));
        o_ldata   = (w_raw & w_keep) | ((w_sign && !i_uns) ? ~w_keep : '0);
    end
endmodule

// File: rtl/risc_v_lsu.sv
// rtl/risc_v_lsu.sv - multi-cycle load/store FSM; RISC_V_LSU_SPLIT_EN enables two-beat word-crossing accesses
module risc_v_lsu
    import risc_v_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    risc_v_lsu_if.master bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t        r_state;
    logic              r_store, r_uns, r_mem_req_valid, r_mem_we;
    logic              r_resp_valid, r_resp_err, r_rd_we;
    size_t             r_size;
    logic [OFF_W-1:0]  r_off;
    logic [4:0]        r_rd, r_rd_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NB-1:0]     r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata, r_rd_data;
`ifdef RISC_V_LSU_SPLIT_EN
    logic              r_split;
    logic [XLEN-1:0]   r_wdata, r_rdata_lo;
`endif

    logic [XLEN-1:0]   w_imm, w_ea, w_a_wdata, w_a_rdata_lo, w_wdata, w_ldata;
    size_t             w_req_size, w_a_size;
    logic [OFF_W-1:0]  w_req_off, w_a_off;
    logic [NB-1:0]     w_be;
    logic              w_cross, w_err, w_idle, w_a_hi;

    assign w_imm      = {{(XLEN-12){bus.req_imm[11]}}, bus.req_imm};
    assign w_ea       = bus.req_base + w_imm;
    assign w_req_size = size_t'(bus.req_funct3[1:0]);
    assign w_req_off  = w_ea[OFF_W-1:0];
    assign w_cross    = (int'(w_req_off) + int'(size_bytes(w_req_size))) > NB;
    assign w_idle     = (r_state == S_IDLE);
    assign w_a_size   = w_idle ? w_req_size : r_size;
    assign w_a_off    = w_idle ? w_req_off : r_off;

    // The aligner serves the incoming request while idle and the captured access afterwards.
`ifdef RISC_V_LSU_SPLIT_EN
    assign w_err        = !f3_legal(bus.req_store, bus.req_funct3, XLEN == 64);
    assign w_a_hi       = (r_state == S_WAIT);
    assign w_a_wdata    = w_idle ? bus.req_wdata : r_wdata;
    assign w_a_rdata_lo = (r_state == S_WAIT2) ? r_rdata_lo : bus.mem_rdata;
`else
    assign w_err        = !f3_legal(bus.req_store, bus.req_funct3, XLEN == 64) || w_cross;
    assign w_a_hi       = 1'b0;
    assign w_a_wdata    = bus.req_wdata;
    assign w_a_rdata_lo = bus.mem_rdata;
`endif

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (w_a_size),
        .i_off      (w_a_off),
        .i_hi       (w_a_hi),
        .i_uns      (r_uns),
        .i_wdata    (w_a_wdata),
        .i_rdata_lo (w_a_rdata_lo),
        .i_rdata_hi (bus.mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_store <= 1'b0;  r_uns <= 1'b0;  r_size <= SZ_B;  r_off <= '0;  r_rd <= '0;
            r_mem_req_valid <= 1'b0;  r_mem_we <= 1'b0;  r_mem_addr <= '0;
            r_mem_be <= '0;  r_mem_wdata <= '0;
            r_resp_valid <= 1'b0;  r_resp_err <= 1'b0;  r_rd_we <= 1'b0;
            r_rd_addr <= '0;  r_rd_data <= '0;
`ifdef RISC_V_LSU_SPLIT_EN
            r_split <= 1'b0;  r_wdata <= '0;  r_rdata_lo <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_we      <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_store <= bus.req_store;
                    r_uns   <= bus.req_funct3[2];
                    r_size  <= w_req_size;
                    r_off   <= w_req_off;
                    r_rd    <= bus.req_rd;
                    if (w_err) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_rd_addr    <= bus.req_rd;
                    end else begin
                        r_state         <= S_REQ;
                        r_mem_req_valid <= 1'b1;
                        r_mem_we        <= bus.req_store;
                        r_mem_addr      <= ADDR_W'(w_ea & ~XLEN'(NB - 1));
                        r_mem_be        <= w_be;
                        r_mem_wdata     <= w_wdata;
`ifdef RISC_V_LSU_SPLIT_EN
                        r_split         <= w_cross;
                        r_wdata         <= bus.req_wdata;
`endif
                    end
                end
                S_REQ: if (bus.mem_req_ready) begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= S_WAIT;
                end
                S_WAIT: if (bus.mem_resp_valid) begin
`ifdef RISC_V_LSU_SPLIT_EN
                    if (r_split) begin
                        r_rdata_lo      <= bus.mem_rdata;
                        r_state         <= S_REQ2;
                        r_mem_req_valid <= 1'b1;
                        r_mem_addr      <= r_mem_addr + ADDR_W'(NB);
                        r_mem_be        <= w_be;
                        r_mem_wdata     <= w_wdata;
                    end else
`endif
                    begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_rd_we      <= !r_store && (r_rd != 5'd0);
                        r_rd_addr    <= r_rd;
                        if (!r_store) r_rd_data <= w_ldata;
                    end
                end
`ifdef RISC_V_LSU_SPLIT_EN
                S_REQ2: if (bus.mem_req_ready) begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= S_WAIT2;
                end
                S_WAIT2: if (bus.mem_resp_valid) begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_rd_we      <= !r_store && (r_rd != 5'd0);
                    r_rd_addr    <= r_rd;
                    if (!r_store) r_rd_data <= w_ldata;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = w_idle;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_err      = r_resp_err;
    assign bus.rd_we         = r_rd_we;
    assign bus.rd_addr       = r_rd_addr;
    assign bus.rd_data       = r_rd_data;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_be        = r_mem_be;
    assign bus.mem_wdata     = r_mem_wdata;
endmodule

// File: doc/risc_v_lsu.md
# risc_v_lsu

Parametrised multi-cycle load/store unit for the RV32I/RV64I core family. It replaces the single-cycle, zero-latency data-memory path with a registered request/response engine. The engine has the following features:
- Computes the effective address.
- Drives a variable-latency valid/ready data-memory bus with byte enables.
- Aligns and sign/zero-extends load data.
- Flags illegal or misaligned accesses.

It sits between the decode stage and data memory and returns register-file writeback information.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 and 64.
- `ADDR_W`, 32: memory address width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  operation offered.
- `req_ready`  out  1  unit idle and able to accept.
- `req_store`  in  1  1 = store (opcode 0100011), 0 = load (0000011).
- `req_funct3`  in  3  instruction[14:12].
- `req_base`  in  XLEN  rs1 value.
- `req_imm`  in  12  I/S immediate, sign-extended internally.
- `req_wdata`  in  XLEN  rs2 value (stores).
- `req_rd`  in  5  destination register (loads).
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_err`  out  1  illegal funct3 or misaligned access; valid with `resp_valid`.
- `rd_we`  out  1  register-file write enable.
- `rd_addr`  out  5  writeback register.
- `rd_data`  out  XLEN  extended load data.
- `mem_req_valid`  out  1  bus request.
- `mem_req_ready`  in  1  bus accepts request.
- `mem_we`  out  1  write request.
- `mem_addr`  out  ADDR_W  address aligned to XLEN/8 bytes.
- `mem_be`  out  XLEN/8  byte-lane enables.
- `mem_wdata`  out  XLEN  lane-shifted store data.
- `mem_resp_valid`  in  1  read data or write acknowledge.
- `mem_rdata`  in  XLEN  read data.

## Operation
- **Address:** EA = `req_base` + sext(`req_imm`), modulo 2^XLEN, captured at accept.
  - Byte offset `off` = EA[log2(XLEN/8)-1:0].
  - Access size comes from funct3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double.
- **Legal funct3:**
  - Loads: 000, 001, 010, 100, 101; plus 011 and 110 when XLEN=64.
  - Stores: 000, 001, 010; plus 011 when XLEN=64.
  - Anything else is illegal.
- **Within-word access:** if `off` + size fits within one bus word, the access is one beat, misaligned or not.
- **Word-crossing access:** handled per the Configuration section.
- **Stores:**
  - `mem_be` has `size` consecutive ones starting at lane `off`.
  - `mem_wdata` = `req_wdata` << 8·`off`.
  - `mem_we` = 1.
  - Completion is `rd_we`=0 and `resp_err`=0.
- **Loads:**
  - Select bytes from lane `off` upward.
  - Sign-extend for funct3[2]=0; zero-extend for funct3[2]=1.
  - Write `rd_data` with `rd_we` = (`rd_addr`≠0).
- **Errors:** `resp_err`=1 and `rd_we`=0; no bus activity.
- **FSM states:** IDLE, REQ, WAIT, REQ2, WAIT2, RESP.
  - IDLE→REQ on accept of a legal access.
  - IDLE→RESP on accept of an erroneous access.
  - REQ→WAIT on `mem_req_valid`&&`mem_req_ready`.
  - WAIT→RESP on `mem_resp_valid`, or WAIT→REQ2 if the access is split.
  - REQ2→WAIT2 on handshake.
  - WAIT2→RESP on `mem_resp_valid`.
  - RESP→IDLE unconditionally.
- **Ready:** `req_ready` = (state==IDLE).
- **Stray responses:** `mem_resp_valid` outside WAIT/WAIT2 is ignored.

## Timing
- **Reset values:** all outputs are 0 except `req_ready`=1; state = IDLE.
  - Reset mid-operation aborts immediately; any later bus response is ignored.
- **Accept:** a request is accepted at edge T when `req_valid`&&`req_ready`.
  - `mem_req_valid` rises after T and is held, with all `mem_*` stable, until `mem_req_ready`.
- **Bus response:** `mem_resp_valid` is legal from the cycle after the request handshake.
- **Completion:** `resp_valid` is high for exactly the one cycle after the final `mem_resp_valid`.
  - All writeback outputs are registered.
  - Minimum single-beat latency: accept T, request cycle T+1, response T+2, `resp_valid` T+3.
- **Error latency:** `resp_valid` in cycle T+1.
- **Back-to-back:** the next accept is possible the cycle after `resp_valid`.

## Configuration
- `RISC_V_LSU_SPLIT_EN` defined:
  - A word-crossing access becomes two beats.
  - Beat 1 is the low word with upper lanes; beat 2 is the address + XLEN/8 with lower lanes.
  - Load bytes are merged before extension.
  - Minimum latency is 5 cycles.
- Undefined:
  - A word-crossing access completes with `resp_err`=1 and no bus activity.
  - REQ2/WAIT2 are not built.

## Structure
- **Package `risc_v_pkg`:**
  - `lsu_state_t` enum.
  - `funct3` constants (LB … LWU, SB … SD).
  - `size_t`.
  - Opcode constants `OP_LOAD` and `OP_STORE`.
- **Sub-module `lsu_align`:** combinational.
  - Lane enable generation.
  - Store shift.
  - Load extract/merge and sign/zero extension.
- **`risc_v_lsu`:** holds the FSM and capture registers.

## Test plan
- **Aligned load:** XLEN=32, LW base 0x100, imm 4, rd 5; memory returns 0xDEADBEEF one cycle after the request with ready=1 → `mem_addr`=0x104, `mem_be`=1111, `resp_valid` at T+3, `rd_data`=0xDEADBEEF, `rd_we`=1.
- **Byte loads and store:**
  - LB at EA 0x103 with rdata 0x80xxxxxx → `mem_be`=1000, `rd_data`=0xFFFFFF80.
  - LBU at the same address → `rd_data`=0x00000080.
  - SH rs2 0x1234 at EA 0x102 → `mem_be`=1100, `mem_wdata`=0x12340000.
- **Word-crossing load:** LW at EA 0x102.
  - Macro off → `resp_err`=1 at T+1, `mem_req_valid` never asserted.
  - Macro on → beats at 0x100 (be 1100) and 0x104 (be 0011); rdata 0xAABBxxxx then 0xxxxxCCDD gives 0xCCDDAABB.
- **Illegal funct3:** funct3=011 at XLEN=32, or store funct3=100 → `resp_err`=1, `rd_we`=0, no bus request.
- **Bus stall:** `mem_req_ready` held low 4 cycles, then the response delayed 3 cycles → request fields stable throughout, `req_ready`=0 throughout, and a single `resp_valid` pulse.
- **Reset and corner cases:**
  - Reset asserted in WAIT → outputs 0 and `req_ready`=1 immediately; a late `mem_resp_valid` yields no `resp_valid`.
  - LW to rd 0 → `rd_we`=0.
